// File: rtl/bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// bcd_serial_adder
//
// Digit-serial packed-BCD adder. On an accepted start the operands and the
// carry-in are captured, then one decimal digit is added per clock, least
// significant digit first. A one-cycle done pulse marks the result valid;
// the result stays put until the next accepted start.
//
// Timing for a start accepted at rising edge k:
//   edge k           operands latched, busy rises
//   edge k+1+i       sum digit i written (i = 0 .. DIGITS-1)
//   edge k+DIGITS    DONE entered, c_out valid, done = 1
//   edge k+DIGITS+1  back to IDLE, busy = 0 (a new start is taken at the
//                    following edge, giving back-to-back operation)
//
// Parameters
//   DIGITS  number of BCD digits per operand (>= 1)
//
// Ports
//   clk     clock, rising edge active
//   rst_n   asynchronous active-low reset
//   start   begin an addition (honoured only in IDLE)
//   a, b    packed BCD operands, digit 0 in bits [3:0]
//   c_in    carry into digit 0
//   busy    operation in progress, including the DONE cycle
//   done    one-cycle pulse: sum, c_out and err are valid
//   sum     packed BCD result
//   c_out   decimal carry out of the top digit
//   err     some operand digit was above 9 (result may not be valid BCD)
// ---------------------------------------------------------------------------
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  c_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  c_out,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    // Keep the index at least one bit wide so DIGITS = 1 still elaborates.
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic             accept;
    logic             last_digit;
    logic [3:0]       a_dig;
    logic [3:0]       b_dig;
    logic [4:0]       raw_sum;
    logic [3:0]       sum_dig;
    logic             carry_next;
    logic             bad_digit;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        accept     = 1'b0;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_ADD;
                end
            end
            ST_ADD: begin
                if (last_digit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here: busy is still 1.
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // One-digit decimal adder on the digit selected by idx
    // -----------------------------------------------------------------------
    always_comb begin
        a_dig      = a_q[{idx, 2'b00} +: 4];
        b_dig      = b_q[{idx, 2'b00} +: 4];
        raw_sum    = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
        last_digit = (idx == LAST_IDX);
        bad_digit  = (a_dig > 4'd9) || (b_dig > 4'd9);

        // Adding 6 skips the six unused codes 10..15; the wrap past 15 is
        // dropped and reappears as the decimal carry.
        if (raw_sum > 5'd9) begin
            sum_dig    = raw_sum[3:0] + 4'd6;
            carry_next = 1'b1;
        end else begin
            sum_dig    = raw_sum[3:0];
            carry_next = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            err   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= c_in;
            idx   <= '0;
            sum   <= '0;
            err   <= 1'b0;
        end else if (state == ST_ADD) begin
            sum[{idx, 2'b00} +: 4] <= sum_dig;
            carry <= carry_next;
            err   <= err | bad_digit;
            if (last_digit) begin
                c_out <= carry_next;
            end else begin
                // Held at the last digit so idx never selects past the top.
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_adder
//
// Self-checking bench for bcd_serial_adder with DIGITS = 4. Fixed vectors
// come from a table, random operations are compared with a decimal
// arithmetic reference, and hand-written sequences cover start during an
// operation and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_bcd_serial_adder;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         err;

    int checks = 0;
    int errors = 0;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         er;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic void ref_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic ci, output logic [W-1:0] s,
                                    output logic co, output logic er);
        int modv = 1;
        for (int i = 0; i < D; i++) modv = modv * 10;
        er = 1'b0;
        s  = '0;
        for (int i = 0; i < D; i++)
            if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) er = 1'b1;
        if (!er) begin
            int tot = bcd2int(av) + bcd2int(bv) + int'(ci);
            co = (tot >= modv);
            s  = int2bcd(tot % modv);
        end else begin
            int c = int'(ci);
            for (int i = 0; i < D; i++) begin
                int t = int'(av[4*i +: 4]) + int'(bv[4*i +: 4]) + c;
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) % 16);
                    c = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    c = 0;
                end
            end
            co = c[0];
        end
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            if ($urandom_range(0, 99) < 4) r[4*i +: 4] = 4'($urandom_range(10, 15));
            else                           r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Runs one operation starting at a negedge, ends at the negedge after
    // the return to IDLE so the next call starts back-to-back.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic [W-1:0] es, input logic ec, input logic ee,
                          input string tag);
        int done_at;
        a = av; b = bv; c_in = ci; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        c_in  = 1'($urandom);
        check({tag, " busy_after_start"}, busy, 1);
        done_at = -1;
        for (int j = 1; j <= D + 2 && done_at < 0; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) done_at = j;
        end
        check({tag, " done_latency"}, done_at, D);
        if (done_at == D) begin
            check({tag, " sum"}, sum, es);
            check({tag, " c_out"}, c_out, ec);
            check({tag, " err"}, err, ee);
            check({tag, " busy_in_done"}, busy, 1);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, " busy_after"}, busy, 0);
        check({tag, " done_after"}, done, 0);
        check({tag, " sum_hold"}, sum, es);
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rc, ec, ee;
        int           done_seen;

        tbl.push_back('{16'h0025, 16'h0049, 1'b0, 16'h0074, 1'b0, 1'b0});
        tbl.push_back('{16'h0008, 16'h0008, 1'b1, 16'h0017, 1'b0, 1'b0});
        tbl.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0});
        tbl.push_back('{16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1});
        tbl.push_back('{16'h0025, 16'h0049, 1'b0, 16'h0074, 1'b0, 1'b0});
        tbl.push_back('{16'h5678, 16'h4321, 1'b1, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{16'h1234, 16'h8765, 1'b0, 16'h9999, 1'b0, 1'b0});

        start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        rst_n = 1'b0;
        #3;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset sum", sum, 0);
        check("reset c_out", c_out, 0);
        check("reset err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed vectors
        for (int i = 0; i < tbl.size(); i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, tbl[i].er,
                   $sformatf("vec%0d", i));

        // start re-asserted at edge k+2 and during the DONE cycle
        a = 16'h0025; b = 16'h0049; c_in = 1'b0; start = 1'b1;
        @(posedge clk);                 // edge k
        @(negedge clk);
        start = 1'b0; a = 16'h9999; b = 16'h9999;
        @(posedge clk);                 // edge k+1
        @(negedge clk);
        start = 1'b1; a = 16'h1111; b = 16'h2222; c_in = 1'b1;
        @(posedge clk);                 // edge k+2
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);                 // edge k+3
        @(posedge clk);                 // edge k+4
        @(negedge clk);
        check("ignore done", done, 1);
        check("ignore sum", sum, 16'h0074);
        check("ignore c_out", c_out, 0);
        start = 1'b1;                   // seen at edge k+5, still in DONE
        @(posedge clk);
        @(negedge clk);
        check("ignore_in_done busy", busy, 0);
        check("ignore_in_done sum", sum, 16'h0074);
        start = 1'b0;
        @(negedge clk);

        // Reset asserted at edge k+2
        a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
        @(posedge clk);                 // edge k
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);                 // edge k+1
        @(posedge clk);                 // edge k+2
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset sum", sum, 0);
        check("midreset c_out", c_out, 0);
        check("midreset err", err, 0);
        done_seen = 0;
        for (int j = 0; j < D + 2; j++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        for (int j = 0; j < D + 2; j++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midreset no_done", done_seen, 0);
        run_op(16'h0456, 16'h0789, 1'b1, 16'h1246, 1'b0, 1'b0, "after_reset");

        // Random operations, run back-to-back
        for (int n = 0; n < 150; n++) begin
            ra = rand_operand();
            rb = rand_operand();
            rc = 1'($urandom);
            ref_add(ra, rb, rc, es, ec, ee);
            run_op(ra, rb, rc, es, ec, ee, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
